bcd_keypad_entry: RTL
=====================

// Module: bcd_keypad_entry
// PURPOSE
//  Consumes the 4-bit code from decimal_to_bcd_encoder (0-9 = key, 4'b1111 = no/invalid key).
//  Debounces it, captures one digit per key press into an NUM_DIGITS-deep BCD shift register,
//  and drives a time-multiplexed 7-segment display of the entered number.
//  Sits between the keypad encoder and the board display/number consumers.
// PARAMETERS
//  NUM_DIGITS       4   digits stored and displayed (>=2)
//  DEBOUNCE_CYCLES  4   consecutive identical samples required to accept a code change (>=2)
//  SCAN_DIV         8   clock cycles each display digit stays lit (>=2)
// PORTS
//  clk          in   1               rising-edge clock
//  rst_n        in   1               asynchronous active-low reset
//  bcd_in       in   4               encoder output; 0-9 valid, 10-15 all mean "no key"
//  clear        in   1               sync clear of stored digits and count
//  digit_valid  out  1               1-cycle pulse: digit accepted and shifted in
//  overflow     out  1               1-cycle pulse: key accepted while full, digit dropped
//  digits_out   out  4*NUM_DIGITS    stored digits; [3:0] = newest, [7:4] = previous, ...
//  count        out  $clog2(NUM_DIGITS+1)  digits stored, saturates at NUM_DIGITS
//  full         out  1               count == NUM_DIGITS
//  seg          out  7               {g,f,e,d,c,b,a}, active-high, for lit digit
//  an           out  NUM_DIGITS      one-hot active-high digit enable
// BEHAVIOUR
//  Reset (async): digits_out=0, count=0, full=0, pulses=0, FSM=IDLE, in_q=4'hF, stab_cnt=0,
//   scan_cnt=0, scan_idx=0 -> an=1 (bit0), seg=0 (blank, count=0).
//  Sampling: in_q <= bcd_in each edge; stab_cnt <= (bcd_in==in_q) ? sat_inc(stab_cnt) : 0.
//   stable = (stab_cnt == DEBOUNCE_CYCLES-1); key = stable && in_q<=9; release = stable && in_q>9.
//  FSM (2 states):
//   IDLE: key -> HELD; if !full: shift digits_out left by 4 with in_q in [3:0], count+1,
//         digit_valid<=1; if full: no shift, overflow<=1.
//   HELD: release -> IDLE. Any valid code (incl. different digit) ignored until release.
//  Latency: code held constant from before edge 1 -> digit_valid high in cycle after
//   edge DEBOUNCE_CYCLES+1 (edge 5 at default). Exactly one pulse per press.
//  Glitches shorter than DEBOUNCE_CYCLES samples never accepted nor counted as release.
//  clear: next edge digits_out=0, count=0; FSM and debounce state untouched (a held key is
//   not re-captured). clear and acceptance same cycle: clear wins, no digit_valid/overflow.
//  count/full: count saturates at NUM_DIGITS; full combinational from count.
//  Display scan: scan_cnt 0..SCAN_DIV-1; on wrap scan_idx increments mod NUM_DIGITS.
//   an = 1<<scan_idx. seg = 7-seg of digits_out[4*scan_idx+:4] if scan_idx < count,
//   else 7'h00 (leading blank). Codes: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
//   seg/an combinational from registered state; no glitch requirement beyond that.
//  Reset mid-press: all state cleared; if key still held after reset, it is accepted again
//   after debounce (FSM starts in IDLE).
// TESTING
//  1. Reset, bcd_in=4'hF -> an=0001, seg=00, count=0, no pulses for 100 cycles.
//  2. bcd_in=5 held 20 cycles then 4'hF -> one digit_valid at edge 5, digits_out=0x0005, count=1.
//  3. Press 1,2,3,4 (each held 10 then released 10) -> digits_out=0x1234, full=1; scan shows
//     seg 66,4F,5B,06 on an 0001,0010,0100,1000.
//  4. Full, press 9 -> overflow pulse once, digits_out stays 0x1234, no digit_valid.
//  5. bcd_in=7 for 2 cycles, 4'hF, 7 for 2 cycles -> no digit_valid; then 7 held, switch to 8
//     while HELD -> single capture of 7 only.
//  6. clear asserted in acceptance cycle -> digits_out=0, count=0, no pulse; rst_n low
//     mid-press -> all outputs at reset values immediately.

Source files
------------

// File: rtl/bcd_keypad_entry_if.sv
// Keypad entry bundle: encoder code and clear in,
// captured digits, pulses and display drive out.
interface bcd_keypad_entry_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int CW = $clog2(NUM_DIGITS + 1);

  logic [3:0]              bcd_in;
  logic                    clear;
  logic                    digit_valid;
  logic                    overflow;
  logic [4*NUM_DIGITS-1:0] digits_out;
  logic [CW-1:0]           count;
  logic                    full;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;

  modport master (
    output bcd_in, clear,
    input  digit_valid, overflow, digits_out,
    input  count, full, seg, an
  );

  modport slave (
    input  bcd_in, clear,
    output digit_valid, overflow, digits_out,
    output count, full, seg, an
  );
endinterface

// File: rtl/bcd_keypad_entry.sv
// Debounced BCD keypad capture into a digit shift
// register with a multiplexed 7-segment scan.
module bcd_keypad_entry #(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_DIV        = 8
) (
  input logic              clk,
  input logic              rst_n,
  bcd_keypad_entry_if.slave bus
);
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int SW = $clog2(DEBOUNCE_CYCLES);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  typedef enum logic {IDLE, HELD} state_t;

  state_t                  state;
  logic [3:0]              in_q;
  logic [SW-1:0]           stab_cnt;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [CW-1:0]           cnt;
  logic                    dv;
  logic                    ov;
  logic [DW-1:0]           scan_cnt;
  logic [IW-1:0]           scan_idx;

  logic       stable;
  logic       key;
  logic       rel;
  logic       is_full;
  logic [3:0] lit;

  function automatic logic [6:0] seg7(
    input logic [3:0] d
  );
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  assign stable  = stab_cnt == SW'(DEBOUNCE_CYCLES - 1);
  assign key     = stable && (in_q <= 4'd9);
  assign rel     = stable && (in_q > 4'd9);
  assign is_full = cnt == CW'(NUM_DIGITS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q     <= 4'hF;
      stab_cnt <= '0;
    end else begin
      in_q <= bus.bcd_in;
      if (bus.bcd_in != in_q)
        stab_cnt <= '0;
      else if (!stable)
        stab_cnt <= stab_cnt + SW'(1);
    end
  end

  // clear overrides capture but leaves the FSM alone,
  // so a key held across clear is not taken twice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      digits <= '0;
      cnt    <= '0;
      dv     <= 1'b0;
      ov     <= 1'b0;
    end else begin
      dv <= 1'b0;
      ov <= 1'b0;
      unique case (state)
        IDLE: begin
          if (key) begin
            state <= HELD;
            if (!bus.clear) begin
              if (!is_full) begin
                digits <= {digits[4*NUM_DIGITS-5:0], in_q};
                cnt    <= cnt + CW'(1);
                dv     <= 1'b1;
              end else begin
                ov <= 1'b1;
              end
            end
          end
        end
        HELD: begin
          if (rel)
            state <= IDLE;
        end
      endcase
      if (bus.clear) begin
        digits <= '0;
        cnt    <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == DW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      if (scan_idx == IW'(NUM_DIGITS - 1))
        scan_idx <= '0;
      else
        scan_idx <= scan_idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + DW'(1);
    end
  end

  assign lit = digits[4*scan_idx +: 4];

  assign bus.digit_valid = dv;
  assign bus.overflow    = ov;
  assign bus.digits_out  = digits;
  assign bus.count       = cnt;
  assign bus.full        = is_full;
  assign bus.an          = NUM_DIGITS'(1) << scan_idx;
  assign bus.seg         = (CW'(scan_idx) < cnt) ?
                           seg7(lit) : 7'h00;
endmodule
